// File: rtl/nonce_sweep_ctrl.sv
// Sweeps [nonce_first, nonce_last] over the hash engine in NUM_LANES-nonce batches, stopping on the first H0 < target.
// Launch one cycle after start, then one lane per scan cycle; the engine throttles via eng_done; NONCE_SWEEP_TIMEOUT_EN adds a WAIT watchdog.
module nonce_sweep_ctrl #(
  parameter int NUM_LANES      = 16,
  parameter int LANE_W         = $clog2(NUM_LANES),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       nonce_first,
  input  logic [31:0]       nonce_last,
  input  logic [31:0]       target,
  output logic              eng_start,
  output logic [31:0]       eng_nonce_base,
  input  logic              eng_done,
  output logic [LANE_W-1:0] eng_rd_lane,
  input  logic [31:0]       eng_rd_h0,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [31:0]       found_nonce,
  output logic              aborted,
  output logic              timeout_err,
  output logic [15:0]       batch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SCAN,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [31:0]       last_q, last_d;
  logic [31:0]       target_q, target_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              abort_pend_q, abort_pend_d;
  logic              found_q, found_d;
  logic [31:0]       found_nonce_q, found_nonce_d;
  logic              aborted_q, aborted_d;
  logic              timeout_err_q, timeout_err_d;
  logic [15:0]       batch_cnt_q, batch_cnt_d;
  logic              eng_start_q, eng_start_d;
  logic [31:0]       eng_base_q, eng_base_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

`ifdef NONCE_SWEEP_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`else
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

  // 33-bit sums expose the carry so a sweep ending at 0xFFFFFFFF never wraps to 0.
  logic [32:0] lane_nonce;
  logic [32:0] next_base;
  logic        lane_oor;
  logic        batch_end;
  logic        lane_hit;
  logic        last_lane;

  assign lane_nonce = {1'b0, base_q} + 33'(lane_q);
  assign next_base  = {1'b0, base_q} + 33'(NUM_LANES);
  assign lane_oor   = lane_nonce[32] || (lane_nonce[31:0] > last_q);
  assign batch_end  = next_base[32] || (next_base[31:0] > last_q);
  assign lane_hit   = eng_rd_h0 < target_q;
  assign last_lane  = lane_q == LANE_W'(NUM_LANES - 1);

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    last_d        = last_q;
    target_d      = target_q;
    lane_d        = lane_q;
    abort_pend_d  = abort_pend_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    aborted_d     = aborted_q;
    timeout_err_d = timeout_err_q;
    batch_cnt_d   = batch_cnt_q;
    eng_base_d    = eng_base_q;
`ifdef NONCE_SWEEP_TIMEOUT_EN
    wdog_d        = wdog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d        = nonce_first;
          last_d        = nonce_last;
          target_d      = target;
          found_d       = 1'b0;
          aborted_d     = 1'b0;
          timeout_err_d = 1'b0;
          batch_cnt_d   = '0;
          abort_pend_d  = 1'b0;
          state_d       = (nonce_first > nonce_last) ? S_FINISH : S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        batch_cnt_d = (batch_cnt_q == 16'hFFFF) ? batch_cnt_q : batch_cnt_q + 16'd1;
        lane_d      = '0;
`ifdef NONCE_SWEEP_TIMEOUT_EN
        wdog_d      = '0;
`endif
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          state_d   = S_WAIT;
        end
      end

      // An abort here is only remembered: the engine is always allowed to finish.
      S_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (eng_done) begin
          lane_d = '0;
          if (abort || abort_pend_q) begin
            aborted_d = 1'b1;
            state_d   = S_FINISH;
          end else begin
            state_d   = S_SCAN;
          end
        end
`ifdef NONCE_SWEEP_TIMEOUT_EN
        else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err_d = 1'b1;
          aborted_d     = abort || abort_pend_q;
          state_d       = S_FINISH;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
`endif
      end

      S_SCAN: begin
        if (lane_oor) begin
          aborted_d = abort;
          state_d   = S_FINISH;
        end else if (lane_hit) begin
          found_d       = 1'b1;
          found_nonce_d = lane_nonce[31:0];
          state_d       = S_FINISH;
        end else if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else if (last_lane) begin
          base_d  = next_base[31:0];
          state_d = batch_end ? S_FINISH : S_LAUNCH;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Registered strobes are derived from the state being entered.
    eng_start_d = (state_d == S_LAUNCH);
    if (eng_start_d) eng_base_d = base_d;
    done_d = (state_d == S_FINISH);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      last_q        <= '0;
      target_q      <= '0;
      lane_q        <= '0;
      abort_pend_q  <= 1'b0;
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      aborted_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      batch_cnt_q   <= '0;
      eng_start_q   <= 1'b0;
      eng_base_q    <= '0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
`ifdef NONCE_SWEEP_TIMEOUT_EN
      wdog_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      last_q        <= last_d;
      target_q      <= target_d;
      lane_q        <= lane_d;
      abort_pend_q  <= abort_pend_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      aborted_q     <= aborted_d;
      timeout_err_q <= timeout_err_d;
      batch_cnt_q   <= batch_cnt_d;
      eng_start_q   <= eng_start_d;
      eng_base_q    <= eng_base_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
`ifdef NONCE_SWEEP_TIMEOUT_EN
      wdog_q        <= wdog_d;
`endif
    end
  end

  assign eng_start      = eng_start_q;
  assign eng_nonce_base = eng_base_q;
  assign eng_rd_lane    = lane_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign found          = found_q;
  assign found_nonce    = found_nonce_q;
  assign aborted        = aborted_q;
  assign timeout_err    = timeout_err_q;
  assign batch_cnt      = batch_cnt_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Scoreboard bench for nonce_sweep_ctrl: a nonce-ordered reference model predicts launches and sweep results.
module tb_nonce_sweep_ctrl;

  typedef struct {
    bit          found;
    logic [31:0] nonce;
    bit          aborted;
    bit          tmo;
    int          batches;
    int          delta;
  } res_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] nonce_first = '0;
  logic [31:0] nonce_last = '0;
  logic [31:0] target = '0;
  logic        eng_start;
  logic [31:0] eng_nonce_base;
  logic        eng_done;
  logic [3:0]  eng_rd_lane;
  logic [31:0] eng_rd_h0;
  logic        busy, done, found, aborted, timeout_err;
  logic [31:0] found_nonce;
  logic [15:0] batch_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          last_eng_done_cyc = 0;
  bit          prev_done = 1'b0;

  int          eng_lat = 4;
  int          eng_cnt = 0;
  logic [31:0] eng_base_cap = '0;
  int          h_mode = 1;
  logic [31:0] h_seed = '0;
  bit          force_en = 1'b0;
  logic [31:0] force_n = '0;

  logic [31:0] exp_launch[$];
  res_t        exp_res[$];

  nonce_sweep_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
    .eng_start(eng_start), .eng_nonce_base(eng_nonce_base), .eng_done(eng_done),
    .eng_rd_lane(eng_rd_lane), .eng_rd_h0(eng_rd_h0),
    .busy(busy), .done(done), .found(found), .found_nonce(found_nonce),
    .aborted(aborted), .timeout_err(timeout_err), .batch_cnt(batch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] h0_of(input logic [31:0] n, input int mode, input logic [31:0] seed,
                                        input bit fen, input logic [31:0] fn);
    logic [31:0] x;
    if (mode == 1) return (fen && n == fn) ? 32'h0000_0FFF : 32'hFFFF_FFFF;
    x = n ^ seed;
    x = x * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA77;
    x = x ^ (x >> 13);
    return x;
  endfunction

  always_comb eng_rd_h0 = h0_of(eng_base_cap + 32'(eng_rd_lane), h_mode, h_seed, force_en, force_n);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine: done pulse eng_lat cycles after eng_start; eng_lat==0 never completes.
  initial begin
    eng_done = 1'b0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!reset_n) begin
        eng_cnt = 0;
      end else begin
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) eng_done = 1'b1;
        end
        if (eng_start) begin
          eng_base_cap = eng_nonce_base;
          eng_cnt      = eng_lat;
        end
      end
    end
  end

  // Monitor: pops scoreboard entries on eng_start and done.
  initial begin
    res_t r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset_n) begin
        if (eng_done) last_eng_done_cyc = cyc;
        if (eng_start) begin
          if (exp_launch.size() == 0) begin
            chk("unexpected_launch", 64'(eng_nonce_base), 64'hDEAD);
          end else begin
            chk("launch_base", 64'(eng_nonce_base), 64'(exp_launch.pop_front()));
          end
        end
        if (done) begin
          n_done++;
          chk("done_pulse_width", 64'(prev_done), 64'd0);
          if (exp_res.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
          end else begin
            r = exp_res.pop_front();
            chk("found", 64'(found), 64'(r.found));
            if (r.found) chk("found_nonce", 64'(found_nonce), 64'(r.nonce));
            chk("aborted", 64'(aborted), 64'(r.aborted));
            chk("timeout_err", 64'(timeout_err), 64'(r.tmo));
            chk("batch_cnt", 64'(batch_cnt), 64'(r.batches));
            chk("busy_at_done", 64'(busy), 64'd1);
            if (r.delta >= 0) chk("done_latency", 64'(cyc - last_eng_done_cyc + 1), 64'(r.delta));
            chk("launches_left", 64'(exp_launch.size()), 64'd0);
          end
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  // Reference: first in-range nonce (in order) whose H0 beats the target decides everything.
  task automatic predict(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t, output res_t r);
    longint unsigned lf, ll, hn, endoff, b, k;
    bit hit;
    lf = 64'(f);
    ll = 64'(l);
    r.found = 1'b0; r.nonce = '0; r.aborted = 1'b0; r.tmo = 1'b0; r.batches = 0; r.delta = -1;
    if (lf > ll) return;
    hit = 1'b0;
    hn  = 0;
    for (longint unsigned n = lf; n <= ll && !hit; n++) begin
      if (h0_of(n[31:0], h_mode, h_seed, force_en, force_n) < t) begin
        hit = 1'b1;
        hn  = n;
      end
    end
    endoff    = hit ? hn - lf : ll - lf;
    r.batches = int'(endoff / 16) + 1;
    for (int i = 0; i < r.batches; i++) exp_launch.push_back(32'(lf + 64'(16 * i)));
    b = lf + 64'(16 * (r.batches - 1));
    if (hit) k = hn - b;
    else k = (ll - b + 1 < 15) ? ll - b + 1 : 15;
    r.found = hit;
    r.nonce = hn[31:0];
    r.delta = 2 + int'(k);
  endtask

  task automatic wait_done(input int n0, input int budget);
    for (int i = 0; i < budget && n_done == n0; i++) @(negedge clk);
    chk("sweep_completed", 64'(n_done != n0), 64'd1);
  endtask

  task automatic run_sweep(input logic [31:0] f, input logic [31:0] l, input logic [31:0] t,
                           input bit do_abort, input bit poke);
    res_t r;
    int   n0;
    if (do_abort) begin
      r.found = 1'b0; r.nonce = '0; r.aborted = 1'b1; r.tmo = 1'b0; r.batches = 1; r.delta = 1;
      exp_launch.push_back(f);
    end else begin
      predict(f, l, t, r);
    end
    exp_res.push_back(r);
    n0 = n_done;
    @(negedge clk);
    nonce_first = f; nonce_last = l; target = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nonce_first = $urandom; nonce_last = $urandom; target = $urandom;
    chk("start_to_launch", 64'(eng_start), 64'(f <= l));
    if (poke) begin
      repeat (2) @(negedge clk);
      nonce_first = 32'd0; nonce_last = 32'hFFFF_FFFF; target = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (do_abort) begin
      repeat (3) @(negedge clk);
      abort = 1'b1;
      repeat (2) @(negedge clk);
      abort = 1'b0;
    end
    wait_done(n0, 5000);
    repeat (eng_lat + 3) @(negedge clk);
  endtask

  initial begin
    logic [31:0]     f, l, t;
    longint unsigned lend;
    int              drops;
    res_t            r;

    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_eng_start", 64'(eng_start), 64'd0);
    chk("reset_found", 64'(found), 64'd0);
    chk("reset_batch_cnt", 64'(batch_cnt), 64'd0);
    chk("reset_eng_base", 64'(eng_nonce_base), 64'd0);
    chk("reset_rd_lane", 64'(eng_rd_lane), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    h_mode = 1; eng_lat = 4;
    force_en = 1'b1; force_n = 32'd5;
    run_sweep(32'd0, 32'd15, 32'h0000_1000, 1'b0, 1'b0);
    force_en = 1'b0;
    run_sweep(32'd0, 32'd47, 32'h0000_1000, 1'b0, 1'b1);
    force_en = 1'b1; force_n = 32'd22;
    run_sweep(32'd10, 32'd20, 32'h0000_1000, 1'b0, 1'b0);
    force_en = 1'b0;
    run_sweep(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h0000_1000, 1'b0, 1'b0);
    run_sweep(32'd50, 32'd10, 32'h0000_1000, 1'b0, 1'b0);
    h_mode = 0; eng_lat = 20;
    run_sweep(32'd0, 32'd100, 32'd0, 1'b1, 1'b0);

    for (int s = 0; s < 30; s++) begin
      h_seed  = $urandom;
      eng_lat = $urandom_range(1, 6);
      lend    = 64'($urandom_range(0, 60));
      case ($urandom_range(0, 3))
        0: f = $urandom;
        1: f = 32'hFFFF_FFFF - 32'($urandom_range(0, 40));
        2: f = 32'($urandom_range(0, 1000));
        default: f = $urandom | 32'h0000_0100;
      endcase
      if (lend == 0 && f > 32'd10) l = f - 32'($urandom_range(1, 5));
      else if (64'(f) + lend > 64'hFFFF_FFFF) l = 32'hFFFF_FFFF;
      else l = f + 32'(lend);
      case ($urandom_range(0, 3))
        0: t = 32'd0;
        1: t = 32'h0400_0000;
        2: t = 32'h1000_0000;
        default: t = 32'h4000_0000;
      endcase
      run_sweep(f, l, t, 1'b0, 1'b0);
    end

    // Engine that never completes.
    eng_lat = 0; h_mode = 1; force_en = 1'b0;
    exp_launch.push_back(32'h0000_0100);
`ifdef NONCE_SWEEP_TIMEOUT_EN
    r.found = 1'b0; r.nonce = '0; r.aborted = 1'b0; r.tmo = 1'b1; r.batches = 1; r.delta = -1;
    exp_res.push_back(r);
    drops = n_done;
    @(negedge clk);
    nonce_first = 32'h0000_0100; nonce_last = 32'h0000_0200; target = 32'h0000_1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(drops, 1200);
`else
    r.found = 1'b0;
    @(negedge clk);
    nonce_first = 32'h0000_0100; nonce_last = 32'h0000_0200; target = 32'h0000_1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drops = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) drops++;
    end
    chk("busy_hang", 64'(drops), 64'd0);
    chk("hang_batch_cnt", 64'(batch_cnt), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_batch_cnt", 64'(batch_cnt), 64'd0);
    chk("midreset_eng_base", 64'(eng_nonce_base), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    exp_launch.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", 64'(busy), 64'd0);
`endif
    chk("results_left", 64'(exp_res.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
